// File: rtl/loop_gate_deadtime.sv
// Gate-drive sequencer: turns the synchronized active-low PWM demand into
// mutually exclusive HS/LS gate enables with dead-time, min on-time and blanked OCP.
module loop_gate_deadtime #(
  parameter int DT_W    = 4,
  parameter int DT_HL   = 3,
  parameter int DT_LH   = 3,
  parameter int TMIN_ON = 4,
  parameter int BLANK   = 2,
  parameter int OCNT_W  = 8
) (
  input  logic              CELCLK,
  input  logic              CELRSTN,
  input  logic              CELV,
  input  logic              CELG,
  input  logic              SUB,
  input  logic              en,
  input  logic              pwm_n,
  input  logic              ocp,
  input  logic              ocp_clr,
  output logic              hs_on,
  output logic              ls_on,
  output logic              ocp_lat,
  output logic [OCNT_W-1:0] ocp_cnt,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LS_ON = 3'd1,
    S_DT_LH = 3'd2,
    S_HS_ON = 3'd3,
    S_DT_HL = 3'd4
  } state_t;

  localparam logic [DT_W-1:0] DT_LH_LAST = DT_W'(DT_LH - 1);
  localparam logic [DT_W-1:0] DT_HL_LAST = DT_W'(DT_HL - 1);
  localparam logic [DT_W-1:0] TMIN_C     = DT_W'(TMIN_ON);
  localparam logic [DT_W-1:0] BLANK_C    = DT_W'(BLANK);
  localparam logic [DT_W-1:0] ON_MAX     = '1;

  state_t              state_reg;
  logic [1:0]          sync_reg;
  logic [DT_W-1:0]     dt_cnt_reg;
  logic [DT_W-1:0]     on_cnt_reg;
  logic                hs_reg;
  logic                ls_reg;
  logic                ocp_lat_reg;
  logic [OCNT_W-1:0]   ocp_cnt_reg;
  logic                pwm_req;
  logic                ocp_exit;
  logic                pwm_exit;
  logic                unused_pins;

  // Power pins exist only to match the cell footprint.
  assign unused_pins = ^{CELV, CELG, SUB};

  assign pwm_req  = ~sync_reg[1];
  assign ocp_exit = en && (state_reg == S_HS_ON) && ocp && (on_cnt_reg > BLANK_C);
  assign pwm_exit = (state_reg == S_HS_ON) && !pwm_req && (on_cnt_reg >= TMIN_C);

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      sync_reg    <= 2'b11;
      state_reg   <= S_IDLE;
      hs_reg      <= 1'b0;
      ls_reg      <= 1'b0;
      dt_cnt_reg  <= '0;
      on_cnt_reg  <= '0;
      ocp_lat_reg <= 1'b0;
      ocp_cnt_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], pwm_n};

      // Clear wins over a coincident increment.
      if (ocp_clr)
        ocp_cnt_reg <= '0;
      else if (ocp_exit && (ocp_cnt_reg != '1))
        ocp_cnt_reg <= ocp_cnt_reg + OCNT_W'(1);

      if (!en) begin
        state_reg   <= S_IDLE;
        hs_reg      <= 1'b0;
        ls_reg      <= 1'b0;
        dt_cnt_reg  <= '0;
        on_cnt_reg  <= '0;
        ocp_lat_reg <= 1'b0;
      end else begin
        // The latch holds off HS re-entry until the PWM demand drops.
        if (ocp_exit)
          ocp_lat_reg <= 1'b1;
        else if ((state_reg != S_HS_ON) && !pwm_req)
          ocp_lat_reg <= 1'b0;

        case (state_reg)
          S_IDLE: begin
            dt_cnt_reg <= '0;
            if (pwm_req) begin
              state_reg <= S_DT_LH;
            end else begin
              state_reg <= S_LS_ON;
              ls_reg    <= 1'b1;
            end
          end
          S_LS_ON: begin
            if (pwm_req && !ocp_lat_reg) begin
              state_reg  <= S_DT_LH;
              ls_reg     <= 1'b0;
              dt_cnt_reg <= '0;
            end
          end
          S_DT_LH: begin
            if (dt_cnt_reg == DT_LH_LAST) begin
              state_reg  <= S_HS_ON;
              hs_reg     <= 1'b1;
              on_cnt_reg <= DT_W'(1);
            end else begin
              dt_cnt_reg <= dt_cnt_reg + DT_W'(1);
            end
          end
          S_HS_ON: begin
            if (ocp_exit || pwm_exit) begin
              state_reg  <= S_DT_HL;
              hs_reg     <= 1'b0;
              dt_cnt_reg <= '0;
            end else if (on_cnt_reg != ON_MAX) begin
              on_cnt_reg <= on_cnt_reg + DT_W'(1);
            end
          end
          S_DT_HL: begin
            if (dt_cnt_reg == DT_HL_LAST) begin
              state_reg <= S_LS_ON;
              ls_reg    <= 1'b1;
            end else begin
              dt_cnt_reg <= dt_cnt_reg + DT_W'(1);
            end
          end
          default: begin
            state_reg <= S_IDLE;
            hs_reg    <= 1'b0;
            ls_reg    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hs_on   = hs_reg;
  assign ls_on   = ls_reg;
  assign ocp_lat = ocp_lat_reg;
  assign ocp_cnt = ocp_cnt_reg;
  assign state   = state_reg;

endmodule

// File: doc/loop_gate_deadtime.md
Name: loop_gate_deadtime

Overview:
- Gate-drive sequencer in LOOP/CONTROL of the step-down converter, directly downstream of the 5V NAND2 loop-control cell.
- Consumes that cell's active-low PWM demand and drives mutually exclusive high-side and low-side gate enables.
- Enforces programmable dead-time, minimum high-side on-time, and blanked cycle-by-cycle overcurrent termination.
- Keeps a saturating count of overcurrent events for the control block.

Parameters:
DT_W, 4, width of dead-time/on-time counters
DT_HL, 3, cycles with both gates off after HS turn-off before LS turn-on (1..2^DT_W-1)
DT_LH, 3, cycles with both gates off after LS turn-off before HS turn-on (1..2^DT_W-1)
TMIN_ON, 4, minimum HS on cycles before a PWM-commanded turn-off
BLANK, 2, HS on cycles during which ocp is ignored (BLANK < TMIN_ON)
OCNT_W, 8, width of overcurrent event counter

Ports:
CELCLK  input  1  control clock
CELRSTN  input  1  asynchronous active-low reset
CELV  input  1  supply pin, no logical function
CELG  input  1  ground pin, no logical function
SUB  input  1  substrate pin, no logical function
en  input  1  converter enable, synchronous
pwm_n  input  1  PWM demand from NAND2 output; 0 = request HS on; asynchronous to CELCLK
ocp  input  1  overcurrent comparator; 1 = current limit exceeded; synchronous
ocp_clr  input  1  synchronous clear of ocp_cnt
hs_on  output  1  high-side gate enable
ls_on  output  1  low-side gate enable
ocp_lat  output  1  overcurrent latched for current PWM cycle
ocp_cnt  output  OCNT_W  saturating overcurrent event count
state  output  3  FSM state encoding for debug

Behaviour:
- Clock and reset: one clock, CELCLK. Reset CELRSTN is asynchronous and active-low. In reset: state=IDLE(0), hs_on=0, ls_on=0, ocp_lat=0, ocp_cnt=0, synchronizer flops=1.
- pwm_n input path:
  - Passes through a 2-flop synchronizer.
  - pwm_req = ~(synchronizer output).
  - Latency from a pwm_n edge to pwm_req is 2 cycles.
- Outputs: all registered; hs_on and ls_on are decoded from the registered state. hs_on&ls_on is never 1.
- States: IDLE=0, LS_ON=1, DT_LH=2, HS_ON=3, DT_HL=4.
- en=0: next state is IDLE from any state. Counters clear. ocp_lat clears. ocp_cnt holds.
- IDLE: both gates off. If en=1: go to DT_LH when pwm_req=1, else LS_ON.
- LS_ON: ls_on=1. Go to DT_LH when pwm_req=1 and ocp_lat=0.
- DT_LH:
  - Both gates off for exactly DT_LH cycles, then HS_ON.
  - pwm_req falling during DT_LH does not abort; dead-time completes, and HS_ON then obeys TMIN_ON.
- HS_ON: hs_on=1; on_cnt counts from 1 on the first HS_ON cycle and saturates at 2^DT_W-1.
  - Overcurrent exit: ocp=1 and on_cnt>BLANK -> DT_HL. Same edge: ocp_lat<=1 and ocp_cnt increments, saturating at all-ones.
  - PWM exit: pwm_req=0 and on_cnt>=TMIN_ON -> DT_HL.
  - ocp=1 with on_cnt<=BLANK is ignored.
  - Simultaneous ocp and pwm exit: treated as an overcurrent exit, so the count increments.
- DT_HL: both gates off for exactly DT_HL cycles, then LS_ON.
- ocp_lat clear: clears on the first cycle pwm_req=0 outside HS_ON. An overcurrent therefore blocks HS re-entry until the PWM cycle ends.
- ocp_clr: sets ocp_cnt=0 next cycle. If ocp_clr coincides with an increment, the result is 0.
- Reset mid-operation: both gates drop to 0 immediately (asynchronous). After release, the block resumes from IDLE.

Test Plan:
- Reset, en=1, pwm_n=1 -> IDLE then LS_ON: ls_on=1 from cycle 2 after en, hs_on=0.
- Steady PWM, pwm_n low for 10 cycles per 20-cycle period, defaults:
  - pwm_n falls -> ls_on falls 3 cycles later (2 sync + 1 FSM).
  - hs_on=0 and ls_on=0 for exactly 3 cycles, then hs_on=1.
  - pwm_n rises -> hs_on falls, 3 dead cycles, then ls_on=1.
  - Both outputs are never 1 together.
- Min on-time: pwm_n low for 1 cycle -> hs_on high for exactly TMIN_ON=4 cycles.
- Blanking and OCP:
  - ocp=1 on HS_ON cycle 2 -> ignored.
  - ocp=1 on HS_ON cycle 3 -> hs_on falls next edge, ocp_lat=1, ocp_cnt=1.
  - LS stays on while pwm_n stays low; HS does not re-enter until pwm_n returns high then low.
- Counter saturation and clear, OCNT_W=2:
  - 5 OCP events -> ocp_cnt=3.
  - ocp_clr on the same cycle as a 6th event -> ocp_cnt=0.
- Abort: en=0 during DT_LH, then CELRSTN asserted during HS_ON -> state=0, hs_on=0 and ls_on=0 without waiting for a clock edge; ocp_cnt=0 after reset.
